// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// Holds a registered result per grant and owns the {Z,C,N,V} status register.
module alu_share_arbiter #(
    parameter int W       = 32,
    parameter int CMD_W   = 4,
    parameter int RR_INIT = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         req_valid,
    output logic [1:0]         req_ready,
    input  logic [2*W-1:0]     req_val1,
    input  logic [2*W-1:0]     req_val2,
    input  logic [2*CMD_W-1:0] req_cmd,
    input  logic [1:0]         req_s,
    output logic [1:0]         rsp_valid,
    input  logic [1:0]         rsp_ready,
    output logic [W-1:0]       rsp_res,
    output logic [3:0]         rsp_status,
    output logic [3:0]         sr,
    output logic [W-1:0]       alu_val1,
    output logic [W-1:0]       alu_val2,
    output logic [CMD_W-1:0]   alu_cmd,
    output logic               alu_carry_in,
    input  logic [W-1:0]       alu_res,
    input  logic [3:0]         alu_status
);

    typedef enum logic {IDLE, HOLD} state_t;

    state_t state, state_n;
    logic   owner;
    logic   prio;
    logic   accept;
    logic   take;
    logic   grant;

    always_comb begin
        state_n   = state;
        req_ready = '0;
        grant     = prio;
        if (req_valid == 2'b01)
            grant = 1'b0;
        else if (req_valid == 2'b10)
            grant = 1'b1;
        accept = (state == IDLE) || rsp_ready[owner];
        take   = accept && (|req_valid);
        if (accept) begin
            if (take) begin
                req_ready[grant] = 1'b1;
                state_n          = HOLD;
            end else begin
                state_n = IDLE;
            end
        end
    end

    // With no request pending, grant falls back to prio so the ALU inputs stay defined.
    assign alu_val1     = grant ? req_val1[2*W-1:W] : req_val1[W-1:0];
    assign alu_val2     = grant ? req_val2[2*W-1:W] : req_val2[W-1:0];
    assign alu_cmd      = grant ? req_cmd[2*CMD_W-1:CMD_W] : req_cmd[CMD_W-1:0];
    assign alu_carry_in = sr[2];

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            owner      <= 1'b0;
            prio       <= (RR_INIT != 0);
            rsp_valid  <= '0;
            rsp_res    <= '0;
            rsp_status <= '0;
            sr         <= '0;
        end else begin
            state <= state_n;
            if (take) begin
                rsp_res    <= alu_res;
                rsp_status <= alu_status;
                owner      <= grant;
                rsp_valid  <= grant ? 2'b10 : 2'b01;
                prio       <= ~grant;
                if (req_s[grant])
                    sr <= alu_status;
            end else if (accept) begin
                rsp_valid <= '0;
            end
        end
    end

endmodule
